// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - 16-bit operation sequencer over a shared 4-bit combinational ALU
//
// Runs one 16-bit command through an external 4-bit ALU, one nibble per cycle,
// least-significant nibble first, with the carry registered between nibbles.
//
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd_op, cmd_a, cmd_b   opcode (ADD SUB NOT AND OR XOR LT EQ) and 16-bit operands
//   res_valid/res_ready    result handshake; result held until taken
//   res_y, res_carry,
//   res_zero, res_ovf      registered 16-bit result and flags
//   alu_op, alu_a, alu_b,
//   alu_cin                drive to the 4-bit ALU (all zero outside RUN)
//   alu_y, alu_cout        4-bit ALU result nibble and carry out

module alu_nibble_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_y,
    output logic        res_carry,
    output logic        res_zero,
    output logic        res_ovf,
    output logic [2:0]  alu_op,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic        alu_cin,
    input  logic [3:0]  alu_y,
    input  logic        alu_cout
);

    // Command opcodes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    // ALU opcodes (the ALU has no native subtract; SUB/LT use a + ~b + 1)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [2:0]  op_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [15:0] acc;
    logic        carry_r;   // carry out of the previous nibble
    logic        diff_r;    // sticky "some nibble differed" for EQ

    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic        is_sub;

    logic        b15_eff;
    logic        ovf_fin;
    logic        diff_fin;
    logic [15:0] sum_fin;
    logic [15:0] y_fin;
    logic        c_fin;
    logic        o_fin;

    assign cmd_ready = (state == S_IDLE);

    assign a_nib  = a_r[{idx, 2'b00} +: 4];
    assign b_nib  = b_r[{idx, 2'b00} +: 4];
    assign is_sub = (op_r == OP_SUB) || (op_r == OP_LT);

    // ALU drive is decoded only from captured registers, so nothing from
    // cmd_* reaches the ALU combinationally.
    always_comb begin
        alu_op  = 3'b000;
        alu_a   = 4'h0;
        alu_b   = 4'h0;
        alu_cin = 1'b0;
        if (state == S_RUN) begin
            alu_a = a_nib;
            case (op_r)
                OP_ADD: begin
                    alu_op  = ALU_ADD;
                    alu_b   = b_nib;
                    alu_cin = (idx == 2'd0) ? 1'b0 : carry_r;
                end
                OP_SUB, OP_LT: begin
                    alu_op  = ALU_ADD;
                    alu_b   = ~b_nib;
                    // +1 of the two's complement enters as the first carry in
                    alu_cin = (idx == 2'd0) ? 1'b1 : carry_r;
                end
                OP_NOT: begin
                    alu_op = ALU_NOT;
                    alu_b  = 4'h0;
                end
                OP_AND: begin
                    alu_op = ALU_AND;
                    alu_b  = b_nib;
                end
                OP_OR: begin
                    alu_op = ALU_OR;
                    alu_b  = b_nib;
                end
                OP_XOR, OP_EQ: begin
                    // EQ is XOR per nibble; any nonzero nibble means not equal
                    alu_op = ALU_XOR;
                    alu_b  = b_nib;
                end
                default: begin
                    alu_op = 3'b000;
                    alu_b  = 4'h0;
                end
            endcase
        end
    end

    // Final result, only meaningful in the last RUN cycle (idx == 3), where
    // alu_y is the top nibble and acc already holds the lower three.
    always_comb begin
        sum_fin  = {alu_y, acc[11:0]};
        b15_eff  = is_sub ? ~b_r[15] : b_r[15];
        ovf_fin  = (a_r[15] == b15_eff) && (alu_y[3] != a_r[15]);
        diff_fin = diff_r | (|alu_y);
        y_fin    = sum_fin;
        c_fin    = 1'b0;
        o_fin    = 1'b0;
        case (op_r)
            OP_ADD, OP_SUB: begin
                y_fin = sum_fin;
                c_fin = alu_cout;
                o_fin = ovf_fin;
            end
            OP_LT: begin
                // signed a < b  <=>  sign of (a - b) xor overflow
                y_fin = {15'b0, alu_y[3] ^ ovf_fin};
            end
            OP_EQ: begin
                y_fin = {15'b0, ~diff_fin};
            end
            default: begin
                y_fin = sum_fin;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= 2'd0;
            op_r      <= 3'b000;
            a_r       <= 16'h0000;
            b_r       <= 16'h0000;
            acc       <= 16'h0000;
            carry_r   <= 1'b0;
            diff_r    <= 1'b0;
            res_valid <= 1'b0;
            res_y     <= 16'h0000;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_r    <= cmd_op;
                        a_r     <= cmd_a;
                        b_r     <= cmd_b;
                        acc     <= 16'h0000;
                        idx     <= 2'd0;
                        carry_r <= 1'b0;
                        diff_r  <= 1'b0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc[{idx, 2'b00} +: 4] <= alu_y;
                    carry_r <= alu_cout;
                    diff_r  <= diff_fin;
                    idx     <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        res_y     <= y_fin;
                        res_carry <= c_fin;
                        res_ovf   <= o_fin;
                        res_zero  <= (y_fin == 16'h0000);
                        res_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // cmd_valid is ignored here; result holds until taken
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb/tb_alu_nibble_seq.sv - scoreboard bench for alu_nibble_seq with a 4-bit ALU model

module tb_alu_nibble_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_y;
    logic        res_carry;
    logic        res_zero;
    logic        res_ovf;
    logic [2:0]  alu_op;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic        alu_cin;
    logic [3:0]  alu_y;
    logic        alu_cout;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, NOTO = 3'b010, ANDO = 3'b011;
    localparam logic [2:0] ORO = 3'b100, XORO = 3'b101, LT = 3'b110, EQ = 3'b111;

    typedef struct packed {
        logic [15:0] y;
        logic        c;
        logic        z;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    bit   prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_nibble_seq dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_carry (res_carry),
        .res_zero  (res_zero),
        .res_ovf   (res_ovf),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_y     (alu_y),
        .alu_cout  (alu_cout)
    );

    // 4-bit combinational ALU
    always_comb begin
        alu_y    = 4'h0;
        alu_cout = 1'b0;
        case (alu_op)
            3'b000:  {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
            3'b010:  alu_y = ~alu_a;
            3'b011:  alu_y = alu_a & alu_b;
            3'b100:  alu_y = alu_a | alu_b;
            3'b101:  alu_y = alu_a ^ alu_b;
            default: alu_y = 4'h0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ey, input logic ec, input logic ez, input logic eo,
                         input bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        if (push) begin
            e.y = ey; e.c = ec; e.z = ez; e.o = eo;
            q.push_back(e);
        end
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: latency, ready/valid exclusion and scoreboard compare on handshake
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) accept_cyc = cyc;
            if (res_valid && !prev_valid) begin
                chk("latency", cyc - accept_cyc, 32'd5);
                chk("ready_with_valid", {31'b0, cmd_ready}, 32'd0);
            end
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("res_y", {16'b0, res_y}, {16'b0, e.y});
                    chk("res_carry", {31'b0, res_carry}, {31'b0, e.c});
                    chk("res_zero", {31'b0, res_zero}, {31'b0, e.z});
                    chk("res_ovf", {31'b0, res_ovf}, {31'b0, e.o});
                end
            end
            prev_valid = res_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] tr_a [4];
        logic       tr_c [4];
        bit         seen;
        int         n;
        tr_a = '{4'hF, 4'hF, 4'hF, 4'h7};
        tr_c = '{1'b0, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b1;
        cmd_op = 3'b000; cmd_a = 16'h0; cmd_b = 16'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_res_y", {16'b0, res_y}, 32'd0);
        chk("rst_alu_a", {28'b0, alu_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_ready", {31'b0, cmd_ready}, 32'd1);

        // ADD with nibble trace
        issue(ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("trace_alu_a%0d", k), {28'b0, alu_a}, {28'b0, tr_a[k]});
            chk($sformatf("trace_alu_cin%0d", k), {31'b0, alu_cin}, {31'b0, tr_c[k]});
        end

        issue(SUB,  16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(LT,   16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(LT,   16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(LT,   16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(XORO, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(NOTO, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(ANDO, 16'hABCD, 16'h0F0F, 16'h0B0D, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(ORO,  16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(EQ,   16'hABCD, 16'hABCD, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(EQ,   16'hABCD, 16'hABCC, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        drain();

        // Backpressure: hold result while a new command is pulsed
        res_ready = 1'b0;
        issue(ADD, 16'h1000, 16'h0234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!res_valid && n < 20);
        chk("bp_result_arrives", {31'b0, res_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cmd_op = XORO; cmd_a = 16'h00FF; cmd_b = 16'h0F0F;
            cmd_valid = (k != 1);
            #1;
            chk($sformatf("bp_cmd_ready%0d", k), {31'b0, cmd_ready}, 32'd0);
            chk($sformatf("bp_res_y%0d", k), {16'b0, res_y}, 32'h1234);
            chk($sformatf("bp_res_valid%0d", k), {31'b0, res_valid}, 32'd1);
        end
        @(negedge clk);
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        #1 chk("bp_handshake_ready", {31'b0, cmd_ready}, 32'd0);
        issue(XORO, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // Reset in RUN at idx 2
        issue(ADD, 16'h0A50, 16'h0101, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1 chk("pre_rst_alu_a", {28'b0, alu_a}, 32'hA);
        rst = 1'b1;
        #1;
        chk("mid_rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("mid_rst_res_y", {16'b0, res_y}, 32'd0);
        chk("mid_rst_alu_a", {28'b0, alu_a}, 32'd0);
        chk("mid_rst_alu_b", {28'b0, alu_b}, 32'd0);
        chk("mid_rst_alu_op", {29'b0, alu_op}, 32'd0);
        chk("mid_rst_alu_cin", {31'b0, alu_cin}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (res_valid) seen = 1'b1;
        end
        chk("rst_no_result", {31'b0, seen}, 32'd0);
        issue(ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        chk("queue_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
